muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit in the execute stage, downstream of regfile.

---
 rtl/muldiv_unit_pkg.sv | 37 +++
 rtl/muldiv_iter_core.sv | 50 +++++
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared widths, funct3 codes and FSM state encoding for the multiply/divide unit.
// Optional build macro: MULDIV_EARLY_OUT_EN (see muldiv_unit.sv).
package muldiv_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR   = 5;
    localparam int ITER       = DATA_WIDTH;
    localparam int CNT_W      = $clog2(ITER);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM
    function automatic logic rs1_signed(input logic [2:0] f);
        return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) ||
               (f == F3_DIV) || (f == F3_REM);
    endfunction

    // rs2 is signed for MUL, MULH, DIV, REM
    function automatic logic rs2_signed(input logic [2:0] f);
        return (f == F3_MUL) || (f == F3_MULH) ||
               (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared 64-bit shift datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, one step per enable.
module muldiv_iter_core
    import muldiv_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    en,
    input  logic                    is_div,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] acc
);

    localparam int DW = DATA_WIDTH;

    logic [DW-1:0] op;
    logic [DW:0]   sum;
    logic [DW:0]   rem_sh;
    logic [DW:0]   diff;

    // One candidate step for each operation; the register picks one
    always_comb begin
        sum    = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, op} : '0);
        rem_sh = acc[2*DW-1:DW-1];
        diff   = rem_sh - {1'b0, op};
    end

    // Load {0, a} and b on accept, then shift once per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            op  <= '0;
        end else if (load) begin
            acc <= {{DW{1'b0}}, a};
            op  <= b;
        end else if (en) begin
            if (is_div) begin
                if (diff[DW])
                    acc <= {rem_sh[DW-1:0], acc[DW-2:0], 1'b0};
                else
                    acc <= {diff[DW-1:0], acc[DW-2:0], 1'b1};
            end else begin
                acc <= {sum, acc[DW-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with single-cycle regfile writeback.
// Define MULDIV_EARLY_OUT_EN to skip iteration for zero-operand cases.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] rv1,
    input  logic [DATA_WIDTH-1:0] rv2,
    input  logic [REG_ADDR-1:0]   rd_in,
    output logic                  busy,
    output logic                  wb_we,
    output logic [REG_ADDR-1:0]   wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data
);

    localparam int DW = DATA_WIDTH;

    md_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic [2:0]        f3;
    logic              sign1;
    logic              sign2;
    logic              special;
    logic [DW-1:0]     special_val;
    logic [2*DW-1:0]   acc;

    logic              accept;
    logic              early;
    logic              sp_now;
    logic [DW-1:0]     sp_val_now;
    logic              sg1_now;
    logic              sg2_now;
    logic [DW-1:0]     mag1;
    logic [DW-1:0]     mag2;
    logic [2*DW-1:0]   prod;
    logic [DW-1:0]     quot;
    logic [DW-1:0]     rem;
    logic [DW-1:0]     result;

    // Accept decode: operand magnitudes, forced results and early-out
    always_comb begin
        accept     = start && !busy && (state != MD_RUN);
        sg1_now    = rs1_signed(funct3) && rv1[DW-1];
        sg2_now    = rs2_signed(funct3) && rv2[DW-1];
        mag1       = sg1_now ? -rv1 : rv1;
        mag2       = sg2_now ? -rv2 : rv2;
        sp_now     = 1'b0;
        sp_val_now = '0;
        early      = 1'b0;
        if (funct3[2] && (rv2 == '0)) begin
            sp_now     = 1'b1;
            sp_val_now = funct3[1] ? rv1 : '1;
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (funct3[2])
            early = (rv2 == '0);
        else
            early = (rv1 == '0) || (rv2 == '0);
        if (!funct3[2] && early) begin
            sp_now     = 1'b1;
            sp_val_now = '0;
        end
`endif
    end

    // Sign fix-up of the raw magnitude result
    always_comb begin
        prod = (sign1 ^ sign2) ? -acc : acc;
        quot = (sign1 ^ sign2) ? -acc[DW-1:0] : acc[DW-1:0];
        rem  = sign1 ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
        unique case (f3)
            F3_MUL:                      result = prod[DW-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*DW-1:DW];
            F3_DIV, F3_DIVU:             result = quot;
            default:                     result = rem;
        endcase
        if (special)
            result = special_val;
    end

    muldiv_iter_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .en     ((state == MD_RUN) && !last),
        .is_div (f3[2]),
        .a      (mag1),
        .b      (mag2),
        .acc    (acc)
    );

    // Control FSM with counter and registered writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MD_IDLE;
            busy        <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            cnt         <= '0;
            last        <= 1'b0;
            f3          <= '0;
            sign1       <= 1'b0;
            sign2       <= 1'b0;
            special     <= 1'b0;
            special_val <= '0;
        end else begin
            wb_we <= 1'b0;
            unique case (state)
                MD_RUN: begin
                    if (last) begin
                        state   <= MD_DONE;
                        busy    <= 1'b0;
                        wb_we   <= 1'b1;
                        wb_data <= result;
                        last    <= 1'b0;
                    end else if (cnt == '0) begin
                        last <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        state       <= MD_RUN;
                        busy        <= !early;
                        last        <= early;
                        cnt         <= CNT_W'(ITER - 1);
                        f3          <= funct3;
                        wb_rd       <= rd_in;
                        sign1       <= sg1_now;
                        sign2       <= sg2_now;
                        special     <= sp_now;
                        special_val <= sp_val_now;
                    end else begin
                        state <= MD_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
